// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the simpleMIPS core: fetch handshake, decode,
// and per-instruction sequencing of ALU, immediate, register-file, PC and data-memory controls.
module mc_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  ALUOp,
  output logic        BSel,
  output logic        ext_op,
  output logic        rf_we,
  output logic        rf_dst,
  output logic [1:0]  wb_sel,
  output logic        illegal
);

  localparam logic [1:0] ALU_ADDU = 2'b00;
  localparam logic [1:0] ALU_SUBU = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_ADD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_J
  } cls_e;

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;
  cls_e   dec_cls;

  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  // C_NONE doubles as the "undecodable" result of the decoder.
  always_comb begin
    dec_cls = C_NONE;
    case (instr[31:26])
      6'b000000: begin
        case (instr[5:0])
          6'b100001: dec_cls = C_ADDU;
          6'b100011: dec_cls = C_SUBU;
          default:   dec_cls = C_NONE;
        endcase
      end
      6'b001101: dec_cls = C_ORI;
      6'b100011: dec_cls = C_LW;
      6'b101011: dec_cls = C_SW;
      6'b000100: dec_cls = C_BEQ;
      6'b001111: dec_cls = C_LUI;
      6'b000010: dec_cls = C_J;
      default:   dec_cls = C_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'd0;
    ALUOp    = ALU_ADDU;
    BSel     = 1'b0;
    ext_op   = 1'b0;
    rf_we    = 1'b0;
    rf_dst   = 1'b0;
    wb_sel   = 2'd0;
    illegal  = 1'b0;

    // Datapath controls are held for the whole body of the instruction.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (cls_q)
        C_SUBU, C_BEQ: ALUOp = ALU_SUBU;
        C_ORI: begin
          ALUOp = ALU_OR;
          BSel  = 1'b1;
        end
        C_LW, C_SW: begin
          ALUOp  = ALU_ADD;
          BSel   = 1'b1;
          ext_op = 1'b1;
        end
        C_LUI:   BSel  = 1'b1;
        default: ALUOp = ALU_ADDU;
      endcase
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        case (dec_cls)
          C_J: begin
            pc_we   = 1'b1;
            pc_src  = 2'd2;
            state_d = S_FETCH;
          end
          C_NONE:  state_d = S_ERR;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_BEQ: begin
            pc_src  = 2'd1;
            pc_we   = zero;
            state_d = S_FETCH;
          end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_SW);
        if (dmem_ready) state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_dst  = (cls_q == C_ADDU) || (cls_q == C_SUBU);
        wb_sel  = (cls_q == C_LW) ? 2'd1 : ((cls_q == C_LUI) ? 2'd2 : 2'd0);
        state_d = S_FETCH;
      end
      S_ERR:   illegal = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: each instruction is expanded into a per-cycle schedule of
// inputs and expected outputs from the instruction timing rules, then replayed and compared.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, BSel, ext_op;
  logic        rf_we, rf_dst, illegal;
  logic [1:0]  pc_src, ALUOp, wb_sel;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .resetn(resetn), .instr(instr), .zero(zero),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .ALUOp(ALUOp),
    .BSel(BSel), .ext_op(ext_op), .rf_we(rf_we), .rf_dst(rf_dst),
    .wb_sel(wb_sel), .illegal(illegal)
  );

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [1:0] alu;
    logic       bsel;
    logic       ext;
    logic       rf_we;
    logic       rf_dst;
    logic [1:0] wb_sel;
    logic       illegal;
  } out_t;

  typedef struct packed {
    logic ir;
    logic dr;
    logic z;
    out_t e;
  } ent_t;

  typedef enum {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_ILL} kind_e;

  out_t  got;
  assign got = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, ALUOp,
                BSel, ext_op, rf_we, rf_dst, wb_sel, illegal};

  ent_t  sched[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  string lbl = "reset";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected cycles of one instruction, from fetch through its last cycle.
  task automatic expand(input kind_e k, input int iw, input int dw, input logic z);
    ent_t t;
    out_t body;
    for (int i = 0; i < iw; i++) begin
      t = '0; t.e.imem_req = 1'b1; sched.push_back(t);
    end
    t = '0; t.ir = 1'b1;
    t.e.imem_req = 1'b1; t.e.ir_we = 1'b1; t.e.pc_we = 1'b1;
    sched.push_back(t);

    t = '0; t.ir = 1'b1; t.dr = 1'b1;
    if (k == K_J) begin
      t.e.pc_we = 1'b1; t.e.pc_src = 2'd2; sched.push_back(t);
      return;
    end
    sched.push_back(t);
    if (k == K_ILL) begin
      for (int i = 0; i < 20; i++) begin
        t = '0; t.ir = 1'b1; t.dr = 1'b1; t.e.illegal = 1'b1; sched.push_back(t);
      end
      return;
    end

    body = '0;
    case (k)
      K_SUBU, K_BEQ: body.alu = 2'b01;
      K_ORI: begin body.alu = 2'b10; body.bsel = 1'b1; end
      K_LW, K_SW: begin body.alu = 2'b11; body.bsel = 1'b1; body.ext = 1'b1; end
      K_LUI: body.bsel = 1'b1;
      default: body.alu = 2'b00;
    endcase

    t = '0; t.e = body; t.z = z; t.dr = 1'b1;
    if (k == K_BEQ) begin
      t.e.pc_src = 2'd1; t.e.pc_we = z; sched.push_back(t);
      return;
    end
    sched.push_back(t);

    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= dw; i++) begin
        t = '0; t.e = body; t.e.dmem_req = 1'b1; t.e.dmem_we = (k == K_SW);
        t.dr = (i == dw); t.ir = 1'b1;
        sched.push_back(t);
      end
      if (k == K_SW) return;
    end

    t = '0; t.e = body; t.ir = 1'b1; t.e.rf_we = 1'b1;
    t.e.rf_dst = (k == K_ADDU || k == K_SUBU);
    t.e.wb_sel = (k == K_LW) ? 2'd1 : ((k == K_LUI) ? 2'd2 : 2'd0);
    sched.push_back(t);
  endtask

  task automatic push_idle();
    ent_t t;
    t = '0; t.ir = 1'b1;
    sched.push_back(t);
  endtask

  // Sole comparison point for DUT outputs against the schedule.
  task automatic run(input int n);
    ent_t t;
    int   done = 0;
    while (sched.size() > 0 && done < n) begin
      t = sched.pop_front();
      imem_ready = t.ir; dmem_ready = t.dr; zero = t.z;
      @(negedge clk);
      chk($sformatf("%s_c%0d", lbl, cyc), 32'(got), 32'(t.e));
      @(posedge clk); #1;
      cyc++; done++;
    end
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(got), 32'd0);
    release_reset();

    lbl = "addu"; instr = 32'h00221821;
    push_idle(); expand(K_ADDU, 0, 0, 1'b0);
    chk("len_addu", sched.size(), 5);
    chk("addu_wb_pin", 32'(sched[4].e), 32'(17'b0_0_0_0_0_00_00_0_0_1_1_00_0));
    chk("addu_exec_pin", 32'(sched[3].e), 32'd0);
    run(100);

    lbl = "subu"; instr = 32'h00221823; expand(K_SUBU, 1, 0, 1'b1); run(100);
    lbl = "ori";  instr = 32'h34220005; expand(K_ORI, 0, 0, 1'b0);
    chk("len_ori", sched.size(), 4);
    run(100);
    lbl = "lui";  instr = 32'h3C011234; expand(K_LUI, 2, 0, 1'b0); run(100);

    lbl = "lw"; instr = 32'h8C220004; expand(K_LW, 0, 2, 1'b0);
    chk("len_lw", sched.size(), 7);
    chk("lw_mem_pin", 32'(sched[3].e), 32'(17'b0_1_0_0_0_00_11_1_1_0_0_00_0));
    chk("lw_wb_pin", 32'(sched[6].e), 32'(17'b0_0_0_0_0_00_11_1_1_1_0_01_0));
    run(100);

    lbl = "sw"; instr = 32'hAC220008; expand(K_SW, 0, 1, 1'b0);
    chk("len_sw", sched.size(), 5);
    run(100);

    lbl = "beq1"; instr = 32'h10220003; expand(K_BEQ, 0, 0, 1'b1);
    chk("len_beq", sched.size(), 3);
    chk("beq_taken_pin", 32'(sched[2].e), 32'(17'b0_0_0_0_1_01_01_0_0_0_0_00_0));
    run(100);
    lbl = "beq0"; expand(K_BEQ, 0, 0, 1'b0); run(100);

    lbl = "j"; instr = 32'h08000010; expand(K_J, 0, 0, 1'b0);
    chk("len_j", sched.size(), 2);
    chk("j_decode_pin", 32'(sched[1].e), 32'(17'b0_0_0_0_1_10_00_0_0_0_0_00_0));
    run(100);
    lbl = "after_j"; instr = 32'h00221821; expand(K_ADDU, 0, 0, 1'b0); run(100);

    // sw interrupted by reset while waiting in MEM
    lbl = "sw_rst"; instr = 32'hAC220008; expand(K_SW, 0, 3, 1'b0);
    run(4);
    sched.delete();
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    chk("sw_mem_req", 32'({dmem_req, dmem_we}), 32'd3);
    #1 resetn = 1'b0;
    #1 chk("sw_async_clear", 32'(got), 32'd0);
    release_reset();
    lbl = "post_rst"; instr = 32'h00221821;
    push_idle(); expand(K_ADDU, 0, 0, 1'b0); run(100);

    lbl = "ill"; instr = 32'hFC000000; expand(K_ILL, 0, 0, 1'b0);
    chk("len_ill", sched.size(), 22);
    run(100);
    @(negedge clk);
    chk("ill_sticky", 32'({illegal, imem_req}), 32'd2);
    #1 resetn = 1'b0;
    #1 chk("ill_async_clear", 32'(got), 32'd0);
    release_reset();

    lbl = "badfunct"; instr = 32'h00221820;
    push_idle(); expand(K_ILL, 0, 0, 1'b0); run(100);
    #1 resetn = 1'b0;
    #1 chk("bad_async_clear", 32'(got), 32'd0);
    release_reset();
    lbl = "recover"; instr = 32'h3C011234;
    push_idle(); expand(K_LUI, 0, 0, 1'b0); run(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
